// File: rtl/pipelined_adder_tree_multiplier_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder-tree multiplier.
// Provides the ceiling log2, the pipeline latency and the term count at each tree level.
package mult_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 0;
    span   = value - 1;
    while (span > 0) begin
      result++;
      span = span >> 1;
    end
    return result;
  endfunction

  // Input register, partial-product register, then one register per tree level.
  function automatic int lat_f(input int width);
    return clog2_f(width) + 2;
  endfunction

  function automatic int level_count_f(input int width, input int level);
    int n;
    n = width;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_multiplier_adder_tree_level.sv
// One registered level of the partial-product adder tree: sums adjacent pairs and
// passes an odd leftover term through unchanged; holds its contents while en_i is low.
module adder_tree_level
  import mult_pkg::*;
#(
  parameter  int N_IN  = 2,
  parameter  int DW    = 16,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic [N_IN-1:0][DW-1:0]    terms_i,
  output logic                       valid_o,
  output logic [N_OUT-1:0][DW-1:0]   terms_o
);

  logic [N_OUT-1:0][DW-1:0] sum_d;
  logic [N_OUT-1:0][DW-1:0] sum_q;
  logic                     valid_q;

  // NOTE: assigning a default first means every path writes sum_d, so no latch is inferred.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      sum_d[i] = terms_i[2*i] + terms_i[2*i+1];
    end
    if (N_IN % 2 == 1) sum_d[N_OUT-1] = terms_i[N_IN-1];
  end

  // NOTE: state is updated with <= so every level samples the previous level's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      sum_q   <= sum_d;
      valid_q <= valid_i;
    end
  end

  assign terms_o = sum_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_adder_tree_multiplier.sv
// Fully pipelined WIDTH x WIDTH signed/unsigned multiplier built from registered partial
// products and a pairwise adder tree; the whole pipeline freezes on output backpressure.
module pipelined_adder_tree_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int LAT    = lat_f(WIDTH);
  localparam int LEVELS = LAT - 2;
  localparam int DW     = 2 * WIDTH;

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             v0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      v0_q  <= 1'b0;
    end else if (adv) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= is_signed;
      v0_q  <= in_valid;
    end
  end

  // Signed mode: sign-extended rows, with the MSB row subtracted (its weight is -2^(W-1)).
  logic [DW-1:0]            a_ext;
  logic [WIDTH-1:0][DW-1:0] pp_d;
  logic [WIDTH-1:0][DW-1:0] pp_q;
  logic                     v1_q;

  always_comb begin
    a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    pp_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp_d[i] = b_q[i] ? (a_ext << i) : '0;
    end
    if (sgn_q) pp_d[WIDTH-1] = -pp_d[WIDTH-1];
  end

  // NOTE: the partial-product array is a plain register bank, so it resets like any other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q <= '0;
      v1_q <= 1'b0;
    end else if (adv) begin
      pp_q <= pp_d;
      v1_q <= v0_q;
    end
  end

  logic [LEVELS-1:0] lvl_valid;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = level_count_f(WIDTH, l);
    localparam int N_OUT = level_count_f(WIDTH, l + 1);

    logic [N_IN-1:0][DW-1:0]  terms_in;
    logic [N_OUT-1:0][DW-1:0] terms_out;
    logic                     valid_in;
    logic                     valid_out;

    if (l == 0) begin : g_first
      assign terms_in = pp_q;
      assign valid_in = v1_q;
    end else begin : g_next
      assign terms_in = g_lvl[l-1].terms_out;
      assign valid_in = g_lvl[l-1].valid_out;
    end

    adder_tree_level #(
      .N_IN (N_IN),
      .DW   (DW)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv),
      .valid_i (valid_in),
      .terms_i (terms_in),
      .valid_o (valid_out),
      .terms_o (terms_out)
    );

    assign lvl_valid[l] = valid_out;
  end

  assign p         = g_lvl[LEVELS-1].terms_out[0];
  assign out_valid = lvl_valid[LEVELS-1];
  assign busy      = v0_q | v1_q | (|lvl_valid);

endmodule

// File: tb/tb_pipelined_adder_tree_multiplier.sv
// Self-checking bench: directed vector table and corner sequences on WIDTH=8, then
// randomized traffic on WIDTH=8 and WIDTH=16 scored against an arithmetic reference.
module tb_pipelined_adder_tree_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        rst_w, in_valid_w, in_ready_w, is_signed_w, out_valid_w, out_ready_w, busy_w;
  logic [15:0] a_w, b_w;
  logic [31:0] p_w;

  pipelined_adder_tree_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  pipelined_adder_tree_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst_w), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
    .is_signed(is_signed_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .p(p_w),
    .busy(busy_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: interpret operands as w-bit unsigned or two's complement, multiply, wrap to 2w bits.
  function automatic longint ref_mul(input longint x, input longint y, input bit sgn, input int w);
    longint lim;
    lim = longint'(1) << w;
    x = x & (lim - 1);
    y = y & (lim - 1);
    if (sgn) begin
      if (x >= lim / 2) x = x - lim;
      if (y >= lim / 2) y = y - lim;
    end
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic rand_run(input int w, input int n);
    longint      q[$];
    int          acc, del;
    logic        iv, orr, rs, ir, ov;
    logic [31:0] ra, rb;
    longint      pv;
    acc = 0;
    del = 0;
    for (int c = 0; c < n + 60; c++) begin
      iv  = (c < n) && ($urandom_range(0, 9) < 7);
      orr = (c >= n) || ($urandom_range(0, 3) != 0);
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = 32'(1) << (w - 1);
      if ($urandom_range(0, 7) == 0) rb = '1;
      if (w == 8) begin
        in_valid = iv; a = ra[7:0]; b = rb[7:0]; is_signed = rs; out_ready = orr;
      end else begin
        in_valid_w = iv; a_w = ra[15:0]; b_w = rb[15:0]; is_signed_w = rs; out_ready_w = orr;
      end
      #1;
      ir = (w == 8) ? in_ready : in_ready_w;
      ov = (w == 8) ? out_valid : out_valid_w;
      pv = (w == 8) ? longint'(p) : longint'(p_w);
      if (iv && ir) begin
        q.push_back(ref_mul(longint'(ra), longint'(rb), rs, w));
        acc++;
      end
      if (ov && orr) begin
        check("rand_output_has_pending_input", longint'(q.size() > 0), 1);
        if (q.size() > 0) check((w == 8) ? "rand_product_w8" : "rand_product_w16", pv, q.pop_front());
        del++;
      end
      tick();
    end
    if (w == 8) in_valid = 1'b0; else in_valid_w = 1'b0;
    check("rand_queue_drained", q.size(), 0);
    check("rand_inorder_count", del, acc);
    check("rand_idle_busy", (w == 8) ? busy : busy_w, 0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int idx, sent, got, hold;
    bit first, seen;

    vecs[0] = '{8'd10,  8'd10,  1'b0, 16'd100};
    vecs[1] = '{8'd255, 8'd2,   1'b0, 16'd510};
    vecs[2] = '{8'd255, 8'd255, 1'b0, 16'd65025};
    vecs[3] = '{8'd0,   8'd200, 1'b0, 16'd0};
    vecs[4] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[5] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
    vecs[6] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[7] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01};
    vecs[8] = '{8'h80,  8'hFF,  1'b0, 16'h7F80};
    vecs[9] = '{8'h80,  8'h01,  1'b1, 16'hFF80};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    rst_w = 1'b1; in_valid_w = 1'b0; a_w = '0; b_w = '0; is_signed_w = 1'b0; out_ready_w = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_p", p, 0);
    check("reset_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Single pulse 5*3: valid on the fifth edge counting the accept edge, then gone.
    a = 8'd5; b = 8'd3; is_signed = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      check("pulse_valid_timing", out_valid, longint'(k == 5));
      if (k == 5) check("pulse_product", p, 15);
    end

    // out_ready low while nothing is valid must not stall the pipeline.
    out_ready = 1'b0;
    a = 8'd7; b = 8'd9; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      if (k <= 4) check("nostall_in_ready", in_ready, 1);
      check("nostall_valid", out_valid, longint'(k >= 5));
      if (k >= 5) check("nostall_product_held", p, 63);
    end
    out_ready = 1'b1;
    tick();
    check("nostall_drained", out_valid, 0);

    // Back-to-back table, unsigned then signed, mixed modes adjacent.
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        in_valid = 1'b1; a = vecs[k].a; b = vecs[k].b; is_signed = vecs[k].sgn;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("stream_valid_timing", out_valid, longint'(k >= 4 && k < 14));
      if (out_valid && idx < 10) begin
        check("stream_product", p, vecs[idx].exp);
        idx++;
      end
    end
    check("stream_count", idx, 10);

    // Backpressure: hold out_ready low 3 cycles once the first square appears.
    sent = 0; got = 0; hold = 0; first = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (!first && out_valid) begin first = 1; hold = 3; end
      in_valid = (sent < 6); a = 8'(sent + 1); b = 8'(sent + 1); is_signed = 1'b0;
      out_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        check("bp_held_valid", out_valid, 1);
        check("bp_held_p", p, 1);
        check("bp_in_ready_low", in_ready, 0);
        hold--;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got++;
        if (got == 1) check("bp_release_accepts_input", in_ready, 1);
        check("bp_order", p, got * got);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_delivered", got, 6);
    tick(); tick();
    check("bp_no_duplicate", out_valid, 0);
    check("bp_idle", busy, 0);

    // Reset mid-operation with three pairs in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'(3 + 2 * i); b = 8'(4 + 2 * i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", p, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midrst_no_stale_valid", out_valid, 0);
    end
    check("midrst_in_ready", in_ready, 1);

    // Reset while a product is stalled at the output clears it asynchronously.
    out_ready = 1'b0; a = 8'd9; b = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid) seen = 1; else tick();
    end
    check("stallrst_reached_output", out_valid, 1);
    check("stallrst_product", p, 81);
    rst = 1'b1;
    #1;
    check("stallrst_p", p, 0);
    check("stallrst_out_valid", out_valid, 0);
    check("stallrst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();

    rand_run(8, 400);

    rst_w = 1'b0;
    tick();
    rand_run(16, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_tree_multiplier.md
Name: pipelined_adder_tree_multiplier

Overview:
Parametrised, fully pipelined WIDTH x WIDTH multiplier built as a registered partial-product adder tree. It accepts one operand pair per cycle under a valid/ready handshake and supports a per-transaction signed/unsigned mode. The full pipeline stalls on output backpressure. It is the general-purpose successor to the fixed 8-bit enable-loaded multiplier and sits between operand producers and accumulate/datapath consumers.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
LEVELS, $clog2(WIDTH), number of adder-tree levels (derived localparam, not overridable).
LAT, LEVELS+2, cycles from accepting edge to out_valid (derived localparam).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = both operands two's complement, 0 = both unsigned
out_valid  output  1  p holds a valid product
out_ready  input  1  consumer accepts p this cycle
p  output  2*WIDTH  product
busy  output  1  any pipeline stage holds a valid entry

Behaviour:
- Reset: asynchronous and active-high. Every pipeline register, every valid bit, out_valid and p clear to 0. busy clears to 0. in_ready is 1 while rst is low after reset.
- Reset asserted mid-operation discards all in-flight products. No stale out_valid appears after reset is released.
- Handshake and stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - While stall is high, every stage, including p and out_valid, holds its value.
- Pipeline stages:
  - Stage 0: register a, b, is_signed and valid.
  - Stage 1: form WIDTH partial products of 2*WIDTH bits each and register them.
  - Stages 2..LEVELS+1: each stage is one pairwise adder-tree level, registered.
  - An odd operand count at a level passes the leftover term through unchanged.
  - The final sum drives p.
- Latency: exactly LAT cycles with no stalls (WIDTH=8 gives LAT=5). Each stall cycle adds one cycle.
- Throughput: one product per cycle when out_ready is held high.
- Arithmetic:
  - Unsigned: p = a*b exactly, zero-extended partial products.
  - Signed: p = $signed(a)*$signed(b) in 2*WIDTH-bit two's complement. Use sign-extended partial products, with the MSB partial product negated (subtracted). Baugh-Wooley is an allowed equivalent.
  - All tree adders are 2*WIDTH bits wide; carries above bit 2*WIDTH-1 are discarded. The result is exact in both modes, with no overflow.
- is_signed travels with its data through every stage. Mixed modes back-to-back are legal.
- in_valid=0 cycles insert bubbles. The valid bit propagates as 0 and p is not required to be stable during bubbles.
- Boundary cases:
  - Simultaneous stall release and new input: accepted on the same edge.
  - out_ready low with out_valid low is not a stall; the pipeline advances.
- busy = OR of all stage valid bits.

Decomposition:
- Package mult_pkg:
  - function clog2_f.
  - localparam function for LAT.
  - Typedef-free constants: MAX_WIDTH = 32.
- One natural sub-module, adder_tree_level: a parameterised count-in/count-out registered pairwise adder with odd pass-through, stall enable and async reset. It is instantiated LEVELS times by a generate loop.
- Partial-product generation stays in the top module.

Test Plan:
1. WIDTH=8, unsigned, a=5, b=3, single pulse, out_ready=1 -> out_valid high exactly 5 cycles after the accept edge, p=15, then out_valid low.
2. Unsigned back-to-back pairs (10,10), (255,2), (255,255), (0,200) on consecutive cycles -> p = 100, 510, 65025, 0 on four consecutive cycles starting at cycle 5.
3. Signed: (0xFF,0xFF), (0x80,0x7F), (0x80,0x80), (0x7F,0x7F) -> p = 0x0001, 0xC080 (-16256), 0x4000 (16384), 0x3F01 (16129).
4. Backpressure: stream 1*1..6*6 while holding out_ready=0 for 3 cycles once the first result appears:
   - p=1 is held for those 3 cycles and in_ready=0.
   - Afterwards 1, 4, 9, 16, 25, 36 arrive in order with none lost or duplicated.
5. Reset mid-operation: accept 3 pairs, then assert rst for 1 cycle at cycle 2:
   - out_valid=0, p=0 and busy=0 immediately, asynchronously.
   - No product from the flushed pairs ever appears.
6. Random regression, WIDTH=8 and WIDTH=16, with random is_signed, in_valid and out_ready -> a scoreboard matches every product against the reference * operator and in-order count.
